seg_frame_reader: RTL and testbench

- Receive side of the board's multiplexed 7-segment display bus.
- Observes the active-low segment pattern and one-hot digit select that the display driver scans out.
- Debounces each digit's pattern and maps it back to a BCD value with blank/error status.
- Publishes a complete multi-digit frame atomically; used for display loopback self-test and for reading back on-board status displays.

---
 rtl/seg_display_pkg.sv | 25 ++
 rtl/seg_pattern_to_bcd.sv | 36 +++
 rtl/seg_frame_reader.sv | 140 ++++++++++++++
 tb/tb_seg_frame_reader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared 7-segment constants for the display driver and reader, plus reader FSM states.
// Latency: none (package only).
// Backpressure: not applicable.
package seg_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_HOLD = 1'b1
    } rd_state_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Maps an active-low a..g segment pattern back to BCD with blank/invalid flags.
// Latency: combinational.
// Backpressure: none.
module seg_pattern_to_bcd
    import seg_display_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        value   = 4'd0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default: begin
                value   = BCD_INVALID;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_frame_reader.sv
// Debounces a scanned 7-seg bus and publishes whole decoded frames; DP capture under SEG_FRAME_READER_DP_EN.
// Latency: capture on the (STABLE_CYCLES+1)th stable edge; publish one edge after the last digit is captured.
// Backpressure: none; the bus is observed passively and frame_valid is a one-cycle pulse.
module seg_frame_reader
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    err_out,
    output logic                    frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES - 1);

    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [CW-1:0]           cnt;
    logic                    in_chg;
    logic                    stable;
    logic                    capture;
    logic                    full;
    logic [IW-1:0]           idx;
    rd_state_t               state, state_nxt;

    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   err_slot;
    logic [NUM_DIGITS-1:0]   blank_slot;
    logic [4*NUM_DIGITS-1:0] value_slot;

    logic [3:0]              dec_value;
    logic                    dec_blank;
    logic                    dec_invalid;

    // cnt tracks how long the registered copy has been steady, so it is judged against the incoming sample
    assign in_chg = ({seg_in, dig_sel} != {seg_q, sel_q});
    assign stable = (cnt == CNT_TOP) && $onehot(sel_q);
    assign full   = &mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            seg_q <= seg_in;
            sel_q <= dig_sel;
            if (in_chg || !$onehot(dig_sel))
                cnt <= '0;
            else if (cnt != CNT_TOP)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (sel_q[k]) idx = IW'(k);
    end

    seg_pattern_to_bcd u_dec (
        .pattern (seg_q[6:0]),
        .value   (dec_value),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (stable)  state_nxt = S_HOLD;
            S_HOLD:  if (!stable) state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        capture = (state == S_WAIT) && stable;
    end

    // Publish clears mask/errors first; a same-edge capture then lands in the fresh frame
    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= '0;
            err_slot    <= '0;
            blank_slot  <= '0;
            value_slot  <= '0;
            value_out   <= '0;
            blank_out   <= '0;
            err_out     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= full;
            if (full) begin
                value_out <= value_slot;
                blank_out <= blank_slot;
                err_out   <= |err_slot;
                mask      <= '0;
                err_slot  <= '0;
            end
            if (capture) begin
                mask[idx]              <= 1'b1;
                err_slot[idx]          <= dec_invalid;
                blank_slot[idx]        <= dec_blank;
                value_slot[idx*4 +: 4] <= dec_value;
            end
        end
    end

`ifdef SEG_FRAME_READER_DP_EN
    logic [NUM_DIGITS-1:0] dp_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_slot <= '0;
            dp_out  <= '0;
        end else begin
            if (full)    dp_out       <= dp_slot;
            if (capture) dp_slot[idx] <= ~seg_q[7];
        end
    end
`else
    assign dp_out = '0;
`endif

endmodule

// File: tb/tb_seg_frame_reader.sv
// Directed bench for seg_frame_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value_out;
    logic [3:0]  blank_out;
    logic [3:0]  dp_out;
    logic        err_out;
    logic        frame_valid;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;

`ifdef SEG_FRAME_READER_DP_EN
    localparam logic [3:0] DP_EXP = 4'b0010;
`else
    localparam logic [3:0] DP_EXP = 4'b0000;
`endif

    seg_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .value_out   (value_out),
        .blank_out   (blank_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Inputs applied at the falling edge are seen by exactly n rising edges
    task automatic drive(input logic [7:0] s, input logic [3:0] d, input int n);
        @(negedge clk);
        seg_in  = s;
        dig_sel = d;
        repeat (n) @(posedge clk);
    endtask

    task automatic idle();
        drive(8'hFF, 4'b0000, 3);
        @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3, input int n);
        drive(p0, 4'b0001, n);
        drive(p1, 4'b0010, n);
        drive(p2, 4'b0100, n);
        drive(p3, 4'b1000, n);
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        seg_in  = 8'hFF;
        dig_sel = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value_out, 16'h0000);
        check("rst_blank", blank_out, 4'b0000);
        check("rst_dp",    dp_out,    4'b0000);
        check("rst_err",   err_out,   1'b0);
        check("rst_fv",    frame_valid, 1'b0);
        rst = 1'b0;

        // Dwell one short of STABLE_CYCLES+1: nothing may be captured
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9, 3);
        check("short_fv",    fv_cnt,    0);
        check("short_value", value_out, 16'h0000);

        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9, 6);
        check("t1_fv",    fv_cnt,    1);
        check("t1_value", value_out, 16'h1234);
        check("t1_blank", blank_out, 4'b0000);
        check("t1_err",   err_out,   1'b0);
        check("t1_dp",    dp_out,    4'b0000);

        scan4(8'hD5, 8'hB0, 8'hFF, 8'hF9, 6);
        check("t3_fv",    fv_cnt,    2);
        check("t3_value", value_out, 16'h103F);
        check("t3_blank", blank_out, 4'b0100);
        check("t3_err",   err_out,   1'b1);
        scan4(8'h99, 8'hB0, 8'hA4, 8'hF9, 6);
        check("t3_clean_fv",    fv_cnt,    3);
        check("t3_clean_err",   err_out,   1'b0);
        check("t3_clean_blank", blank_out, 4'b0000);

        drive(8'hF9, 4'b0011, 10);
        drive(8'h92, 4'b0001, 6);
        drive(8'h82, 4'b0010, 6);
        drive(8'hF8, 4'b0100, 6);
        idle();
        check("t4_partial_fv", fv_cnt, 3);
        drive(8'h80, 4'b1000, 6);
        idle();
        check("t4_fv",    fv_cnt,    4);
        check("t4_value", value_out, 16'h8765);

        drive(8'h98, 4'b0001, 6);
        drive(8'h98, 4'b0010, 6);
        drive(8'h98, 4'b0100, 6);
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_value", value_out, 16'h0000);
        check("t5_rst_blank", blank_out, 4'b0000);
        check("t5_rst_err",   err_out,   1'b0);
        check("t5_rst_fv",    fv_cnt,    4);
        drive(8'hB0, 4'b1000, 5);
        idle();
        check("t5_one_digit_fv", fv_cnt, 4);
        drive(8'hC0, 4'b0001, 5);
        drive(8'hF9, 4'b0010, 5);
        drive(8'hA4, 4'b0100, 5);
        idle();
        check("t5_fv",    fv_cnt,    5);
        check("t5_value", value_out, 16'h3210);

        // Digit 0 recaptured (last one wins); digit 1 has its DP lit
        drive(8'h99, 4'b0001, 6);
        drive(8'h98, 4'b0001, 6);
        drive(8'h79, 4'b0010, 6);
        drive(8'h92, 4'b0100, 6);
        drive(8'hF8, 4'b1000, 6);
        idle();
        check("t6_fv",    fv_cnt,    6);
        check("t6_value", value_out, 16'h7519);
        check("t6_dp",    dp_out,    DP_EXP);
        check("t6_err",   err_out,   1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
